// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter and its load/store aligner.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_ERR
    } arb_state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_DM
    } arb_owner_t;

    typedef logic [3:0] mem_be_t;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LH  = 3'd1,
        LD_LW  = 3'd2,
        LD_LBU = 3'd4,
        LD_LHU = 3'd5
    } i_load_funct3_t;

    typedef enum logic [2:0] {
        ST_SB = 3'd0,
        ST_SH = 3'd1,
        ST_SW = 3'd2
    } s_store_funct3_t;

    localparam mem_be_t BE_ALL = 4'b1111;

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 inside {ST_SB, ST_SH, ST_SW};
        end
        return funct3 inside {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// Combinational load/store lane logic: store byte enables and replicated data,
// access-fault detection, and load byte/half extraction with sign/zero extension.
module lsu_align
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            we,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output mem_be_t         st_be,
    output logic [XLEN-1:0] st_wdata,
    output logic            err,
    input  logic [1:0]      ld_offset,
    input  logic [2:0]      ld_funct3,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data
);

    logic        misaligned;
    logic [15:0] lane;

    assign misaligned = ((funct3[1:0] == 2'd1) && offset[0])
                     || ((funct3[1:0] == 2'd2) && (offset != 2'd0));
    assign err = !funct3_legal(we, funct3) || misaligned;

    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        st_be    = BE_ALL;
        st_wdata = '0;
        if (we) begin
            case (funct3)
                ST_SB: begin
                    st_be    = mem_be_t'(4'b0001 << offset);
                    st_wdata = {(XLEN/8){wdata[7:0]}};
                end
                ST_SH: begin
                    st_be    = mem_be_t'(4'b0011 << offset);
                    st_wdata = {(XLEN/16){wdata[15:0]}};
                end
                ST_SW:   st_wdata = wdata;
                default: st_be    = '0;
            endcase
        end
    end

    always_comb begin
        lane    = 16'(rdata >> {ld_offset, 3'b000});
        ld_data = rdata;
        case (ld_funct3)
            LD_LB:   ld_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
            LD_LH:   ld_data = {{(XLEN-16){lane[15]}}, lane};
            LD_LBU:  ld_data = {{(XLEN-8){1'b0}}, lane[7:0]};
            LD_LHU:  ld_data = {{(XLEN-16){1'b0}}, lane};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by instruction fetch and the MEM stage,
// with DM priority, bounded IF starvation and load/store formatting.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [XLEN-1:0]       if_rdata_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [2:0]            dm_funct3_i,
    input  logic [XLEN-1:0]       dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [XLEN-1:0]       dm_rdata_o,
    output logic                  dm_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output mem_be_t               mem_be_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i
);

    localparam logic [7:0]            STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    arb_state_t            state, state_next;
    arb_owner_t            owner;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    mem_be_t               be_q;
    logic [XLEN-1:0]       wdata_q;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic [7:0]            starve_cnt;
    logic                  rsp_if, rsp_dm;
    logic [XLEN-1:0]       rsp_data;

    mem_be_t               st_be;
    logic [XLEN-1:0]       st_wdata;
    logic                  dm_fault;
    logic [XLEN-1:0]       ld_data;
    logic                  any_req, if_wins;

    lsu_align #(.XLEN(XLEN)) u_lsu_align (
        .we        (dm_we_i),
        .offset    (dm_addr_i[1:0]),
        .funct3    (dm_funct3_i),
        .wdata     (dm_wdata_i),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .err       (dm_fault),
        .ld_offset (offset_q),
        .ld_funct3 (funct3_q),
        .rdata     (mem_rdata_i),
        .ld_data   (ld_data)
    );

    assign any_req = if_req_i || dm_req_i;
    assign if_wins = if_req_i && (!dm_req_i || (starve_cnt == STARVE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            // NOTE: non-blocking, so every register in the design samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:  if (any_req) state_next = (!if_wins && dm_fault) ? ARB_ERR : ARB_ISSUE;
            ARB_ISSUE: if (mem_ready_i) state_next = ARB_WAIT;
            ARB_WAIT:  if (mem_rvalid_i) state_next = ARB_IDLE;
            ARB_ERR:   state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;
        dm_err_o    = 1'b0;
        mem_req_o   = 1'b0;
        case (state)
            ARB_ISSUE: begin
                mem_req_o = 1'b1;
                if_gnt_o  = mem_ready_i && (owner == OWNER_IF);
                dm_gnt_o  = mem_ready_i && (owner == OWNER_DM);
            end
            ARB_ERR: begin
                dm_gnt_o = 1'b1;
                dm_err_o = 1'b1;
            end
            default: ;
        endcase
        if_rvalid_o = rsp_if;
        dm_rvalid_o = rsp_dm || (state == ARB_ERR);
        if_rdata_o  = rsp_if ? rsp_data : '0;
        dm_rdata_o  = rsp_dm ? rsp_data : '0;
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

    // Request fields are frozen at arbitration; later requester changes are not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWNER_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            offset_q   <= '0;
            starve_cnt <= '0;
            rsp_if     <= 1'b0;
            rsp_dm     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp_if <= 1'b0;
            rsp_dm <= 1'b0;
            if (state == ARB_IDLE) begin
                if (!if_req_i || if_wins) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != 8'hFF) begin
                    starve_cnt <= starve_cnt + 8'd1;
                end
                if (any_req && if_wins) begin
                    owner    <= OWNER_IF;
                    addr_q   <= if_addr_i & WORD_MASK;
                    we_q     <= 1'b0;
                    be_q     <= BE_ALL;
                    wdata_q  <= '0;
                    funct3_q <= LD_LW;
                    offset_q <= 2'd0;
                end else if (any_req) begin
                    owner    <= OWNER_DM;
                    addr_q   <= dm_addr_i & WORD_MASK;
                    we_q     <= dm_we_i;
                    be_q     <= st_be;
                    wdata_q  <= st_wdata;
                    funct3_q <= dm_funct3_i;
                    offset_q <= dm_addr_i[1:0];
                end
            end
            if ((state == ARB_WAIT) && mem_rvalid_i) begin
                rsp_if   <= (owner == OWNER_IF);
                rsp_dm   <= (owner == OWNER_DM);
                rsp_data <= (owner == OWNER_IF) ? mem_rdata_i : (we_q ? '0 : ld_data);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// single transactions compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int XLEN  = 32;
    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            if_req_i = 1'b0;
    logic [AW-1:0]   if_addr_i = '0;
    logic            if_gnt_o, if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;
    logic            dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [AW-1:0]   dm_addr_i = '0;
    logic [2:0]      dm_funct3_i = '0;
    logic [XLEN-1:0] dm_wdata_i = '0;
    logic            dm_gnt_o, dm_rvalid_o, dm_err_o;
    logic [XLEN-1:0] dm_rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_ready_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [XLEN-1:0] mem_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    logic [138:0] all_outs;
    assign all_outs = {if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
                       dm_err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o};

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .dm_req_i     (dm_req_i),
        .dm_we_i      (dm_we_i),
        .dm_addr_i    (dm_addr_i),
        .dm_funct3_i  (dm_funct3_i),
        .dm_wdata_i   (dm_wdata_i),
        .dm_gnt_o     (dm_gnt_o),
        .dm_rvalid_o  (dm_rvalid_o),
        .dm_rdata_o   (dm_rdata_o),
        .dm_err_o     (dm_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: access size from funct3, legality list, and lane arithmetic on integers.
    function automatic void ref_dm(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                                   input logic [31:0] wd, input logic [31:0] word,
                                   output bit err, output logic [3:0] be,
                                   output logic [31:0] mwd, output logic [31:0] rd);
        int unsigned     off, size;
        bit              legal;
        longint unsigned lane, span;
        off   = addr % 4;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        err   = !legal || ((addr % size) != 0);
        be    = 4'hF;
        mwd   = '0;
        rd    = '0;
        if (err) return;
        if (we) begin
            be = 4'(((1 << size) - 1) << off);
            case (size)
                1:       mwd = (wd % 256) * 32'h0101_0101;
                2:       mwd = (wd % 65536) * 32'h0001_0001;
                default: mwd = wd;
            endcase
        end else begin
            span = 64'd1 << (8 * size);
            lane = (longint'(word) >> (8 * off)) % span;
            if (!f3[2] && size < 4 && lane >= span / 2) rd = 32'(lane - span);
            else rd = 32'(lane);
        end
    endfunction

    // One complete transaction from a lone requester, checked cycle by cycle.
    task automatic txn(input bit is_if, input bit we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] word,
                       input int rdy_wait, input int rsp_wait, input bit spurious);
        bit          e;
        logic [3:0]  be;
        logic [31:0] mwd, rd;
        if (is_if) begin
            e = 1'b0; be = 4'hF; mwd = '0; rd = word;
        end else begin
            ref_dm(we, addr, f3, wd, word, e, be, mwd, rd);
        end
        @(negedge clk);
        if (is_if) begin
            if_req_i = 1'b1; if_addr_i = addr;
        end else begin
            dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_funct3_i = f3; dm_wdata_i = wd;
        end
        #1;
        check("idle_quiet", {mem_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}, 0);
        if (e) begin
            @(negedge clk); #1;
            check("err_pulse", {dm_gnt_o, dm_rvalid_o, dm_err_o, if_gnt_o, mem_req_o}, 5'b11100);
            check("err_rdata", dm_rdata_o, 0);
            @(negedge clk); dm_req_i = 1'b0; #1;
            check("err_one_cycle", {dm_gnt_o, dm_rvalid_o, dm_err_o, mem_req_o}, 0);
            return;
        end
        for (int k = 0; k <= rdy_wait; k++) begin
            @(negedge clk);
            mem_ready_i  = (k == rdy_wait);
            mem_rvalid_i = spurious && (k == 0) && (rdy_wait > 0);
            mem_rdata_i  = $urandom;
            #1;
            check("issue_req", mem_req_o, 1);
            check("issue_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
            check("issue_we_be", {mem_we_o, mem_be_o}, {!is_if && we, be});
            if (!is_if && we) check("issue_wdata", mem_wdata_o, mwd);
            check("issue_gnt", {if_gnt_o, dm_gnt_o},
                  (k == rdy_wait) ? (is_if ? 2'b10 : 2'b01) : 2'b00);
        end
        for (int j = 0; j <= rsp_wait; j++) begin
            @(negedge clk);
            if_req_i = 1'b0; dm_req_i = 1'b0; mem_ready_i = 1'b0;
            mem_rvalid_i = (j == rsp_wait);
            mem_rdata_i  = (j == rsp_wait) ? word : $urandom;
            #1;
            check("wait_quiet", {mem_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}, 0);
        end
        @(negedge clk);
        mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
        #1;
        check("rsp_valid", {if_rvalid_o, dm_rvalid_o, dm_err_o}, is_if ? 3'b100 : 3'b010);
        check("rsp_data", is_if ? if_rdata_o : dm_rdata_o, rd);
    endtask

    int          model_cnt, ngr;
    bit          pending, exp_if;
    bit          r_if, r_we, r_sp;
    logic [31:0] r_addr, r_wd, r_word;
    logic [2:0]  r_f3;

    initial begin
        #1;
        check("reset_outputs", all_outs, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("post_reset_idle", all_outs, 0);

        // Reset while a fetch is waiting for its response; the stale response must vanish.
        @(negedge clk); if_req_i = 1'b1; if_addr_i = 32'h80; #1;
        @(negedge clk); mem_ready_i = 1'b1; #1;
        check("rst_pre_gnt", if_gnt_o, 1);
        @(negedge clk); if_req_i = 1'b0; mem_ready_i = 1'b0; #1;
        check("rst_pre_wait", mem_req_o, 0);
        rst = 1'b1; #1;
        check("rst_async_outputs", all_outs, 0);
        @(negedge clk); rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; #1;
        check("rst_stale_rvalid", all_outs, 0);
        @(negedge clk); mem_rvalid_i = 1'b0; #1;
        check("rst_no_rvalid", all_outs, 0);
        txn(1'b1, 1'b0, 32'h100, 3'd2, 32'h0, 32'h1234_5678, 0, 0, 1'b0);

        // Both requesters held: DM wins LIMIT times, then IF, and the pattern repeats.
        if_req_i = 1'b1; if_addr_i = 32'h200;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300; dm_funct3_i = 3'd2;
        mem_ready_i = 1'b1;
        pending = 1'b0; ngr = 0; model_cnt = 0;
        for (int cyc = 0; cyc < 200 && ngr < 10; cyc++) begin
            @(negedge clk);
            mem_rvalid_i = pending; mem_rdata_i = $urandom; pending = 1'b0;
            #1;
            if (if_gnt_o || dm_gnt_o) begin
                exp_if = (model_cnt == LIMIT);
                check("starve_owner", {if_gnt_o, dm_gnt_o}, exp_if ? 2'b10 : 2'b01);
                model_cnt = exp_if ? 0 : model_cnt + 1;
                pending = 1'b1;
                ngr++;
            end
        end
        check("starve_grants", ngr, 10);
        @(negedge clk);
        if_req_i = 1'b0; dm_req_i = 1'b0; mem_ready_i = 1'b0;
        mem_rvalid_i = pending; pending = 1'b0;
        @(negedge clk); mem_rvalid_i = 1'b0; #1;
        check("starve_last_if_rvalid", if_rvalid_o, 1);

        // Directed lane cases.
        txn(1'b0, 1'b1, 32'h1003, 3'd0, 32'hAB, 32'h0, 0, 0, 1'b0);
        txn(1'b0, 1'b0, 32'h2001, 3'd0, 32'h0, 32'h0000_8000, 0, 0, 1'b0);
        txn(1'b0, 1'b0, 32'h2001, 3'd4, 32'h0, 32'h0000_8000, 0, 0, 1'b0);
        txn(1'b0, 1'b0, 32'h2002, 3'd1, 32'h0, 32'h8000_0000, 0, 0, 1'b0);
        txn(1'b0, 1'b0, 32'h3002, 3'd2, 32'h0, 32'h0, 0, 0, 1'b0);
        txn(1'b0, 1'b1, 32'h3000, 3'd3, 32'h55, 32'h0, 0, 0, 1'b0);
        txn(1'b0, 1'b0, 32'h400, 3'd2, 32'h0, 32'hCAFE_F00D, 3, 1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            r_if   = ($urandom_range(0, 3) == 0);
            r_we   = $urandom_range(0, 1) == 1;
            r_addr = $urandom & 32'h0000_3FFF;
            r_f3   = 3'($urandom_range(0, 7));
            r_wd   = $urandom;
            r_word = $urandom;
            r_sp   = $urandom_range(0, 1) == 1;
            txn(r_if, r_we, r_addr, r_f3, r_wd, r_word,
                $urandom_range(0, 3), $urandom_range(0, 2), r_sp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, single-outstanding memory bus between instruction fetch (IF) and the MEM-stage data access (DM).
- Owns arbitration with DM priority and IF anti-starvation, plus the request/response FSM.
- Generates store byte enables and lanes; aligns and sign/zero-extends load data from funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Sits between the pipeline front/MEM stages and the memory model or bus bridge.

Parameters:
XLEN, 32, data width.
ADDR_WIDTH, 32, address width.
STARVE_LIMIT, 4, consecutive DM wins while IF waits before IF is forced to win (1..255).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
if_req_i  in  1  fetch request, held until if_gnt_o
if_addr_i  in  ADDR_WIDTH  fetch address; bits [1:0] forced to 0
if_gnt_o  out  1  one-cycle pulse: fetch accepted by memory
if_rvalid_o  out  1  one-cycle pulse: if_rdata_o valid
if_rdata_o  out  XLEN  instruction word
dm_req_i  in  1  data request, held until dm_gnt_o
dm_we_i  in  1  1 = store
dm_addr_i  in  ADDR_WIDTH  byte address
dm_funct3_i  in  3  load/store funct3
dm_wdata_i  in  XLEN  store data (low bits significant)
dm_gnt_o  out  1  one-cycle pulse: data request accepted
dm_rvalid_o  out  1  one-cycle pulse: completion (load data or store ack)
dm_rdata_o  out  XLEN  extended load data; 0 for stores and errors
dm_err_o  out  1  with dm_rvalid_o: misaligned or illegal funct3
mem_req_o  out  1  bus request (registered)
mem_we_o  out  1  bus write
mem_addr_o  out  ADDR_WIDTH  word-aligned address
mem_be_o  out  4  byte enables
mem_wdata_o  out  XLEN  lane-replicated store data
mem_ready_i  in  1  bus accepts when mem_req_o && mem_ready_i
mem_rvalid_i  in  1  response pulse, earliest cycle after accept
mem_rdata_i  in  XLEN  response word

Behaviour:
- Reset (async, active-high): state ARB_IDLE; starve_cnt 0. All outputs are 0 and stay 0 until first arbitration.
- FSM states: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ERR.
- ARB_IDLE:
  - No request: stay.
  - Winner: IF if if_req_i && (!dm_req_i || starve_cnt == STARVE_LIMIT), else DM.
  - Latch owner, address, we, be, wdata, funct3.
  - DM with error → ARB_ERR; otherwise → ARB_ISSUE.
- ARB_ISSUE: mem_req_o=1 with latched fields. On mem_ready_i, pulse the owner's gnt_o that same cycle → ARB_WAIT.
- ARB_WAIT: mem_req_o=0. On mem_rvalid_i, capture data → ARB_IDLE. Next cycle (registered), pulse owner rvalid_o with formatted rdata.
- ARB_ERR: one cycle. dm_gnt_o=dm_rvalid_o=dm_err_o=1, dm_rdata_o=0 → ARB_IDLE. No bus activity.
- Latency with mem_ready_i=1 and 1-cycle memory:
  - req@0 → mem_req_o/gnt@1 → mem_rvalid_i@2 → rvalid_o@3.
  - Next arbitration occurs in the ARB_IDLE cycle after capture; the returning rvalid_o pulse overlaps it.
- Requests sampled only in ARB_IDLE. Requester changes before gnt are ignored, since fields are latched in ARB_IDLE.
- mem_rvalid_i outside ARB_WAIT is ignored. This covers stale responses after reset.
- Starvation counter:
  - +1 (saturating) when DM wins while if_req_i=1.
  - Cleared when IF wins, or when in ARB_IDLE with if_req_i=0.
  - ARB_ERR wins count as DM wins.
- Stores:
  - SB: be = 0001 << addr[1:0], wdata = {4{b}}.
  - SH: be = 0011 << addr[1:0], wdata = {2{h}}.
  - SW: be = 1111.
  - Store completion: dm_rvalid_o=1, dm_rdata_o=0.
- Loads:
  - mem_be_o=1111.
  - Extract byte/half at addr[1:0]; sign-extend LB/LH, zero-extend LBU/LHU.
- Error conditions:
  - Misaligned: half with addr[0]=1, word with addr[1:0]≠0.
  - Illegal funct3: load 3/6/7, store ≥3.
- IF responses: raw mem_rdata_i; if_err never raised.

Decomposition:
- Shared package additions:
  - arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ERR}
  - arb_owner_t {OWNER_IF, OWNER_DM}
  - mem_be_t (logic [3:0])
  - Reuse I_LOAD_FUNCT3 and S_STORE_FUNCT3.
- One sub-module, lsu_align: combinational store be/wdata generation, load extract/extend, misalign/illegal detection.

Test Plan:
- Reset mid-ARB_WAIT, then mem_rvalid_i pulse → no rvalid_o; all outputs 0; next if_req_i, addr 0x100, serviced normally.
- Simultaneous if_req_i and dm_req_i, both held, STARVE_LIMIT=4 → DM granted 4 times, IF 5th; counter then 0.
- SB addr 0x1003, wdata 0xAB → mem_be_o=1000, mem_wdata_o=0xABABABAB, mem_addr_o=0x1000; dm_rvalid_o with rdata 0.
- LB addr 0x2001, mem_rdata_i=0x0000_8000 → dm_rdata_o=0xFFFFFF80. LBU same → 0x00000080. LH addr 0x2002 with mem_rdata_i=0x80000000 → 0xFFFF8000.
- LW addr 0x3002 → no mem_req_o; next cycle dm_gnt_o=dm_rvalid_o=dm_err_o=1, rdata 0.
- mem_ready_i low 3 cycles in ARB_ISSUE → mem_req_o held with stable addr, gnt only on 4th cycle; spurious mem_rvalid_i in ARB_ISSUE ignored.
